sumador_param: RTL
==================

// Module: sumador_param
// PURPOSE
//   Parametrised successor of the 8-bit sumador accumulator. Holds a WIDTH-bit
//   running value and applies add, subtract, load or clear operations to it.
//   Add and subtract run through a SLICE_W-bit carry chain over several cycles,
//   one slice per clock, least significant slice first.
//   Supports saturation, a sticky overflow flag and a valid/ready operand port.
//   It sits behind the tt_um top-level wrapper, which maps ui_in, uio_in and
//   uo_out onto its ports.
// PARAMETERS
//   WIDTH    8   accumulator and operand width; must be a multiple of SLICE_W
//   SLICE_W  4   bits added per clock; NSLICE = WIDTH/SLICE_W cycles per add/sub
// PORTS
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous reset, active-high
//   enable      in   1      global enable; 0 freezes all registers
//   op_valid    in   1      operation request
//   op_ready    out  1      = enable & (state==IDLE); accept = op_valid & op_ready
//   op_mode     in   2      00 add, 01 sub, 10 load, 11 clear
//   operand     in   WIDTH  operand, sampled on the accept edge
//   sat_en      in   1      saturate on overflow, sampled on the accept edge
//   ovf_clr     in   1      clears ovf_sticky
//   out         out  WIDTH  accumulator value
//   cout        out  1      raw carry out of the last add/sub (1 = no borrow on sub)
//   ovf_sticky  out  1      set on any unsigned overflow/underflow
//   done        out  1      one-cycle pulse, high in the cycle after out updates
// BEHAVIOUR
//   Reset (async, rst=1)
//     - out=0, cout=0, ovf_sticky=0, done=0, state=IDLE, slice index=0.
//     - Reset during CALC aborts the operation; no done is produced.
//   FSM states: IDLE, CALC.
//   add / sub
//     - The accept edge latches the operand (inverted for sub), the mode and sat_en.
//     - The carry-in is 1 for sub and 0 for add. State moves IDLE->CALC.
//     - Each CALC edge computes slice k of out+op into a shadow register and keeps
//       the carry.
//     - On the edge for slice NSLICE-1: out and cout are written, state goes to
//       IDLE, and done is registered high for exactly one cycle.
//     - Latency: accept at edge E0, out valid after edge E0+NSLICE.
//     - op_ready is high again in the done cycle, so one op completes every
//       NSLICE+1 cycles at most.
//   load / clear
//     - The accept edge writes out=operand (load) or out=0 (clear), with cout=0.
//     - State stays IDLE. done is high the next cycle. Back-to-back accepts are
//       allowed every cycle.
//   Overflow
//     - Overflow is cout=1 on add, or cout=0 (borrow) on sub.
//     - sat_en=1: out = all ones (add) or 0 (sub). cout still reports the raw carry.
//     - sat_en=0: the result wraps modulo 2^WIDTH.
//     - ovf_sticky is set on overflow. ovf_clr clears it; if a set and a clear
//       happen in the same cycle, the set wins.
//   Operations that complete on the same edge update out exactly once.
//     Requests not accepted (op_ready=0) are ignored; they are not queued.
//   enable=0
//     - FSM, slice index, shadow, out, cout, ovf_sticky and done all hold.
//       op_ready=0.
//     - CALC resumes when enable returns. The result is identical, only delayed.
// TESTING (WIDTH=8, SLICE_W=4, NSLICE=2)
//   - After reset: load 0x05, then add 0x0A -> out=0x0F, cout=0 two edges after
//     accept. done high one cycle. ovf_sticky=0.
//   - out=0xF0, add 0x20, sat_en=0 -> out=0x10, cout=1, ovf_sticky=1.
//     Repeat with sat_en=1 -> out=0xFF.
//   - out=0x10, sub 0x20 -> out=0xF0, cout=0, ovf_sticky=1. With sat_en=1 -> 0x00.
//     Sub 0x10 from 0x30 -> 0x20, cout=1.
//   - enable=0 for 3 cycles during CALC -> same result 3 cycles later, op_ready=0
//     meanwhile. ovf_clr on the same edge as a new overflow -> ovf_sticky stays 1.
//   - rst pulsed during CALC -> out=0 immediately, no done pulse, op_ready=1 after
//     release. Then load 0xA5, clear -> 0xA5, 0x00 on consecutive edges.
//   - WIDTH=16, SLICE_W=8: 0x00FF + 0x0001 = 0x0100, cout=0.
//     0xFFFF + 0x0001 -> 0x0000, cout=1.

Source files
------------

// File: rtl/sumador_param.sv
// Parametrised multi-cycle accumulator: add/sub through a SLICE_W-bit carry chain,
// one slice per clock, plus single-cycle load/clear, saturation and sticky overflow.
module sumador_param #(
  parameter int WIDTH   = 8,
  parameter int SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_mode,
  input  logic [WIDTH-1:0] operand,
  input  logic             sat_en,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf_sticky,
  output logic             done
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic {IDLE, CALC} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_LOAD = 2'b10, OP_CLEAR = 2'b11} op_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_op;
  logic [WIDTH-1:0]   r_shadow;
  logic [WIDTH-1:0]   r_out;
  logic               r_carry;
  logic               r_sub;
  logic               r_sat;
  logic               r_cout;
  logic               r_ovf;
  logic               r_done;

  int                 w_base;
  logic [SLICE_W:0]   w_slice_sum;
  logic [WIDTH-1:0]   w_result;
  logic               w_carry;
  logic               w_ovf;
  logic               w_last;
  logic               w_accept;

  assign op_ready   = enable & (r_state == IDLE);
  assign w_accept   = op_valid & op_ready;
  assign out        = r_out;
  assign cout       = r_cout;
  assign ovf_sticky = r_ovf;
  assign done       = r_done;

  assign w_base  = int'(r_idx) * SLICE_W;
  assign w_carry = w_slice_sum[SLICE_W];
  // Subtraction adds the inverted operand plus one, so a missing carry is a borrow.
  assign w_ovf   = r_sub ? ~w_carry : w_carry;
  assign w_last  = (r_state == CALC) && (r_idx == LAST_IDX);

  // NOTE: every always_comb output gets a full default first, so no latch can be inferred.
  always_comb begin
    w_slice_sum = {1'b0, r_out[w_base +: SLICE_W]} + {1'b0, r_op[w_base +: SLICE_W]}
                + (SLICE_W + 1)'(r_carry);
    w_result = r_shadow;
    w_result[w_base +: SLICE_W] = w_slice_sum[SLICE_W-1:0];
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_op     <= '0;
      r_shadow <= '0;
      r_out    <= '0;
      r_carry  <= 1'b0;
      r_sub    <= 1'b0;
      r_sat    <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else if (enable) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (op_t'(op_mode))
              OP_ADD, OP_SUB: begin
                r_sub   <= op_mode[0];
                r_op    <= op_mode[0] ? ~operand : operand;
                r_carry <= op_mode[0];
                r_sat   <= sat_en;
                r_idx   <= '0;
                r_state <= CALC;
              end
              OP_LOAD: begin
                r_out  <= operand;
                r_cout <= 1'b0;
                r_done <= 1'b1;
              end
              OP_CLEAR: begin
                r_out  <= '0;
                r_cout <= 1'b0;
                r_done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          r_carry  <= w_carry;
          r_shadow <= w_result;
          if (w_last) begin
            r_state <= IDLE;
            r_cout  <= w_carry;
            r_done  <= 1'b1;
            if (w_ovf && r_sat) r_out <= r_sub ? '0 : '1;
            else                r_out <= w_result;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A new overflow outranks a clear arriving on the same edge.
      if (w_last && w_ovf) r_ovf <= 1'b1;
      else if (ovf_clr)    r_ovf <= 1'b0;
    end
  end

endmodule
